// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle: decode outputs and pipeline control going in,
// E register fields, ALU/condition results and CC coming back out.
interface execute_stage_if #(
    parameter int WORD = 64
);
    logic [2:0]      d_stat;
    logic [3:0]      d_icode;
    logic [3:0]      d_ifun;
    logic [WORD-1:0] d_valC;
    logic [WORD-1:0] d_valA;
    logic [WORD-1:0] d_valB;
    logic [3:0]      d_dstE;
    logic [3:0]      d_dstM;
    logic [3:0]      d_srcA;
    logic [3:0]      d_srcB;
    logic            E_stall;
    logic            E_bubble;
    logic [2:0]      m_stat;
    logic [2:0]      W_stat;

    logic [2:0]      E_stat;
    logic [3:0]      E_icode;
    logic [3:0]      E_ifun;
    logic [WORD-1:0] E_valC;
    logic [WORD-1:0] E_valA;
    logic [WORD-1:0] E_valB;
    logic [3:0]      E_dstE;
    logic [3:0]      E_dstM;
    logic [3:0]      E_srcA;
    logic [3:0]      E_srcB;
    logic [WORD-1:0] e_valE;
    logic [3:0]      e_dstE;
    logic            e_Cnd;
    logic [2:0]      cc;

    modport master (
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB,
               E_stall, E_bubble, m_stat, W_stat,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB,
               e_valE, e_dstE, e_Cnd, cc
    );

    modport slave (
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB,
               E_stall, E_bubble, m_stat, W_stat,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB,
               e_valE, e_dstE, e_Cnd, cc
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes,
// jXX/cmovXX condition evaluation and cmov destination squashing.
module execute_stage #(
    parameter int         WORD  = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic          clk,
    input logic          rst,
    execute_stage_if.slave bus
);
    typedef enum logic [3:0] {
        I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
        I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
    } icode_e;

    typedef enum logic [2:0] {
        S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4
    } stat_e;

    typedef enum logic [3:0] {
        F_ADD, F_SUB, F_AND, F_XOR
    } alufn_e;

    logic [2:0]      r_stat;
    logic [3:0]      r_icode;
    logic [3:0]      r_ifun;
    logic [WORD-1:0] r_valC;
    logic [WORD-1:0] r_valA;
    logic [WORD-1:0] r_valB;
    logic [3:0]      r_dstE;
    logic [3:0]      r_dstM;
    logic [3:0]      r_srcA;
    logic [3:0]      r_srcB;
    logic [2:0]      r_cc;

    logic [WORD-1:0] w_aluA;
    logic [WORD-1:0] w_aluB;
    logic [3:0]      w_alufun;
    logic [WORD-1:0] w_result;
    logic            w_zf;
    logic            w_sf;
    logic            w_of;
    logic            w_set_cc;
    logic            w_cnd;
    logic            w_cc_zf;
    logic            w_cc_sf;
    logic            w_cc_of;

    // E pipeline register: reset and bubble both inject a nop; stall holds.
    always_ff @(posedge clk) begin
        if (rst || bus.E_bubble) begin
            r_stat  <= S_AOK;
            r_icode <= I_NOP;
            r_ifun  <= '0;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else if (!bus.E_stall) begin
            r_stat  <= bus.d_stat;
            r_icode <= bus.d_icode;
            r_ifun  <= bus.d_ifun;
            r_valC  <= bus.d_valC;
            r_valA  <= bus.d_valA;
            r_valB  <= bus.d_valB;
            r_dstE  <= bus.d_dstE;
            r_dstM  <= bus.d_dstM;
            r_srcA  <= bus.d_srcA;
            r_srcB  <= bus.d_srcB;
        end
    end

    // ALU operand A select.
    always_comb begin
        w_aluA = '0;
        case (r_icode)
            I_RRMOVQ, I_OPQ:             w_aluA = r_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_aluA = r_valC;
            I_CALL, I_PUSHQ:             w_aluA = -(WORD'(8));
            I_RET, I_POPQ:               w_aluA = WORD'(8);
            default:                     w_aluA = '0;
        endcase
    end

    // ALU operand B select.
    always_comb begin
        w_aluB = '0;
        case (r_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:      w_aluB = r_valB;
            default:                     w_aluB = '0;
        endcase
    end

    assign w_alufun = (r_icode == I_OPQ) ? r_ifun : F_ADD;

    // ALU datapath and the flags it would produce.
    always_comb begin
        w_result = '0;
        w_of     = 1'b0;
        case (w_alufun)
            F_ADD: begin
                w_result = w_aluB + w_aluA;
                w_of     = (w_aluA[WORD-1] == w_aluB[WORD-1]) &&
                           (w_result[WORD-1] != w_aluA[WORD-1]);
            end
            F_SUB: begin
                w_result = w_aluB - w_aluA;
                w_of     = (w_aluB[WORD-1] != w_aluA[WORD-1]) &&
                           (w_result[WORD-1] != w_aluB[WORD-1]);
            end
            F_AND:   w_result = w_aluB & w_aluA;
            F_XOR:   w_result = w_aluB ^ w_aluA;
            default: w_result = '0;
        endcase
    end

    assign w_zf     = (w_result == '0);
    assign w_sf     = w_result[WORD-1];
    assign w_set_cc = (r_icode == I_OPQ) && (bus.m_stat == S_AOK) &&
                      (bus.W_stat == S_AOK);

    // CC register, independent of E_stall; later-stage faults block updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= 3'b100;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    assign w_cc_zf = r_cc[2];
    assign w_cc_sf = r_cc[1];
    assign w_cc_of = r_cc[0];

    // Branch / conditional-move condition from the pre-update CC.
    always_comb begin
        w_cnd = 1'b0;
        if (r_icode == I_RRMOVQ || r_icode == I_JXX) begin
            case (r_ifun)
                4'd0:    w_cnd = 1'b1;
                4'd1:    w_cnd = (w_cc_sf ^ w_cc_of) | w_cc_zf;
                4'd2:    w_cnd = w_cc_sf ^ w_cc_of;
                4'd3:    w_cnd = w_cc_zf;
                4'd4:    w_cnd = !w_cc_zf;
                4'd5:    w_cnd = !(w_cc_sf ^ w_cc_of);
                4'd6:    w_cnd = !(w_cc_sf ^ w_cc_of) && !w_cc_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign bus.E_stat  = r_stat;
    assign bus.E_icode = r_icode;
    assign bus.E_ifun  = r_ifun;
    assign bus.E_valC  = r_valC;
    assign bus.E_valA  = r_valA;
    assign bus.E_valB  = r_valB;
    assign bus.E_dstE  = r_dstE;
    assign bus.E_dstM  = r_dstM;
    assign bus.E_srcA  = r_srcA;
    assign bus.E_srcB  = r_srcB;
    assign bus.e_valE  = w_result;
    assign bus.e_Cnd   = w_cnd;
    assign bus.e_dstE  = (r_icode == I_RRMOVQ && !w_cnd) ? RNONE : r_dstE;
    assign bus.cc      = r_cc;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: an instruction-level model of the E register,
// ALU results, CC and conditions checked every cycle, plus literal anchors.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    execute_stage_if #(.WORD(64)) bus ();

    execute_stage #(.WORD(64), .RNONE(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } ereg_t;

    ereg_t      mE;
    logic [2:0] mcc;

    function automatic ereg_t nop_reg();
        ereg_t e;
        e.stat = 3'd1; e.icode = 4'd1; e.ifun = 4'd0;
        e.valC = 64'd0; e.valA = 64'd0; e.valB = 64'd0;
        e.dstE = 4'hF; e.dstM = 4'hF; e.srcA = 4'hF; e.srcB = 4'hF;
        return e;
    endfunction

    // What each instruction computes in the execute stage.
    function automatic logic [63:0] exp_valE(ereg_t e);
        case (e.icode)
            4'd2:        return e.valA;
            4'd3:        return e.valC;
            4'd4, 4'd5:  return e.valB + e.valC;
            4'd6: case (e.ifun)
                4'd0:    return e.valB + e.valA;
                4'd1:    return e.valB - e.valA;
                4'd2:    return e.valB & e.valA;
                4'd3:    return e.valB ^ e.valA;
                default: return 64'd0;
            endcase
            4'd8, 4'd10: return e.valB - 64'd8;
            4'd9, 4'd11: return e.valB + 64'd8;
            default:     return 64'd0;
        endcase
    endfunction

    // Flags of an OPq, overflow judged by exact 65-bit signed arithmetic.
    function automatic logic [2:0] exp_flags(ereg_t e);
        logic [63:0] r;
        logic [64:0] w;
        logic        of;
        r  = exp_valE(e);
        of = 1'b0;
        if (e.ifun == 4'd0) begin
            w  = {e.valB[63], e.valB} + {e.valA[63], e.valA};
            of = w[64] ^ w[63];
        end else if (e.ifun == 4'd1) begin
            w  = {e.valB[63], e.valB} - {e.valA[63], e.valA};
            of = w[64] ^ w[63];
        end
        return {r == 64'd0, r[63], of};
    endfunction

    function automatic logic exp_cnd(ereg_t e, logic [2:0] c);
        logic zf, lt;
        zf = c[2];
        lt = c[1] ^ c[0];
        if (e.icode != 4'd2 && e.icode != 4'd7) return 1'b0;
        case (e.ifun)
            4'd0:    return 1'b1;
            4'd1:    return lt | zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return ~zf;
            4'd5:    return ~lt;
            4'd6:    return ~lt & ~zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mE  = nop_reg();
            mcc = 3'b100;
        end else begin
            if (mE.icode == 4'd6 && bus.m_stat == 3'd1 && bus.W_stat == 3'd1)
                mcc = exp_flags(mE);
            if (bus.E_bubble) begin
                mE = nop_reg();
            end else if (!bus.E_stall) begin
                mE.stat = bus.d_stat;   mE.icode = bus.d_icode; mE.ifun = bus.d_ifun;
                mE.valC = bus.d_valC;   mE.valA = bus.d_valA;   mE.valB = bus.d_valB;
                mE.dstE = bus.d_dstE;   mE.dstM = bus.d_dstM;
                mE.srcA = bus.d_srcA;   mE.srcB = bus.d_srcB;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("E_stat",  64'(bus.E_stat),  64'(mE.stat));
            chk("E_icode", 64'(bus.E_icode), 64'(mE.icode));
            chk("E_ifun",  64'(bus.E_ifun),  64'(mE.ifun));
            chk("E_valC",  bus.E_valC,       mE.valC);
            chk("E_valA",  bus.E_valA,       mE.valA);
            chk("E_valB",  bus.E_valB,       mE.valB);
            chk("E_dstE",  64'(bus.E_dstE),  64'(mE.dstE));
            chk("E_dstM",  64'(bus.E_dstM),  64'(mE.dstM));
            chk("E_srcA",  64'(bus.E_srcA),  64'(mE.srcA));
            chk("E_srcB",  64'(bus.E_srcB),  64'(mE.srcB));
            chk("cc",      64'(bus.cc),      64'(mcc));
            chk("e_valE",  bus.e_valE,       exp_valE(mE));
            chk("e_Cnd",   64'(bus.e_Cnd),   64'(exp_cnd(mE, mcc)));
            chk("e_dstE",  64'(bus.e_dstE),
                64'((mE.icode == 4'd2 && !exp_cnd(mE, mcc)) ? 4'hF : mE.dstE));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic [3:0] sa, input logic [3:0] sb);
        bus.d_stat = st;  bus.d_icode = ic; bus.d_ifun = fn;
        bus.d_valC = c;   bus.d_valA  = a;  bus.d_valB = b;
        bus.d_dstE = de;  bus.d_dstM  = dm; bus.d_srcA = sa; bus.d_srcB = sb;
    endtask

    task automatic ld_op(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
        ld(3'd1, 4'd6, fn, 64'd0, a, b, 4'd2, 4'hF, 4'd1, 4'd2);
    endtask

    logic [63:0] va [8] = '{64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'd5, 64'd3, 64'd7, 64'h10, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [63:0] vb [8] = '{64'h8000_0000_0000_0000, 64'd2, 64'h8000_0000_0000_0000,
                            64'd3, 64'h0F, 64'd9, 64'h8000_0000_0000_0000, 64'd1};

    initial begin
        bus.E_stall = 1'b0; bus.E_bubble = 1'b0;
        bus.m_stat = 3'd1;  bus.W_stat = 3'd1;
        ld(3'd1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_icode", 64'(bus.E_icode), 64'd1);
        chk("rst_cc",    64'(bus.cc),      64'b100);
        chk("rst_cnd",   64'(bus.e_Cnd),   64'd0);
        chk("rst_dstE",  64'(bus.e_dstE),  64'hF);

        ld_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); tick();
        chk("add_valE", bus.e_valE, 64'h8000_0000_0000_0000);
        ld_op(4'd1, 64'd5, 64'd5); tick();
        chk("add_cc",   64'(bus.cc), 64'b011);
        chk("sub_valE", bus.e_valE, 64'd0);
        ld(3'd1, 4'd2, 4'd4, 64'd0, 64'h55, 64'd0, 4'd3, 4'hF, 4'd1, 4'hF); tick();
        chk("sub_cc",     64'(bus.cc),     64'b100);
        chk("cmovne_cnd", 64'(bus.e_Cnd),  64'd0);
        chk("cmovne_dst", 64'(bus.e_dstE), 64'hF);
        ld(3'd1, 4'd2, 4'd3, 64'd0, 64'h55, 64'd0, 4'd3, 4'hF, 4'd1, 4'hF); tick();
        chk("cmove_cnd", 64'(bus.e_Cnd),  64'd1);
        chk("cmove_dst", 64'(bus.e_dstE), 64'd3);
        chk("cmove_val", bus.e_valE,      64'h55);

        ld_op(4'd2, 64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000); tick();
        ld_op(4'd3, 64'hFF, 64'hFF); tick();
        chk("and_cc",   64'(bus.cc), 64'b010);
        chk("xor_valE", bus.e_valE,  64'd0);
        bus.m_stat = 3'd3;
        ld_op(4'd3, 64'hFF, 64'hFF); tick();
        chk("xor_adr_cc", 64'(bus.cc), 64'b010);
        bus.m_stat = 3'd1;
        ld(3'd1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF); tick();
        chk("xor_aok_cc", 64'(bus.cc), 64'b100);
        ld_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0); tick();
        bus.W_stat = 3'd2;
        ld(3'd1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF); tick();
        chk("w_hlt_cc", 64'(bus.cc), 64'b100);
        bus.W_stat = 3'd1;

        ld(3'd1, 4'd4, 4'd0, 64'h10, 64'h33, 64'h20, 4'hF, 4'hF, 4'd1, 4'd2); tick();
        chk("rmmov_valE", bus.e_valE, 64'h30);
        bus.E_stall = 1'b1;
        ld(3'd1, 4'd5, 4'd0, 64'h99, 64'h0, 64'h40, 4'hF, 4'd7, 4'hF, 4'd3); tick();
        ld(3'd2, 4'd3, 4'd0, 64'h77, 64'h0, 64'h0,  4'd6, 4'hF, 4'hF, 4'hF); tick();
        chk("stall_icode", 64'(bus.E_icode), 64'd4);
        chk("stall_valC",  bus.E_valC,       64'h10);
        chk("stall_srcA",  64'(bus.E_srcA),  64'd1);
        bus.E_bubble = 1'b1; tick();
        chk("bub_icode", 64'(bus.E_icode), 64'd1);
        chk("bub_dstE",  64'(bus.E_dstE),  64'hF);
        chk("bub_dstM",  64'(bus.E_dstM),  64'hF);
        bus.E_bubble = 1'b0; bus.E_stall = 1'b0;

        ld(3'd1, 4'd10, 4'd0, 64'd0, 64'h5, 64'h100, 4'd4, 4'hF, 4'd1, 4'd4); tick();
        chk("push_valE", bus.e_valE,      64'hF8);
        chk("push_dstE", 64'(bus.e_dstE), 64'd4);
        ld(3'd1, 4'd11, 4'd0, 64'd0, 64'hF8, 64'hF8, 4'd4, 4'd5, 4'd4, 4'd4); tick();
        chk("pop_valE", bus.e_valE, 64'h100);
        ld(3'd1, 4'd8, 4'd0, 64'h400, 64'd0, 64'h200, 4'd4, 4'hF, 4'hF, 4'd4); tick();
        chk("call_valE", bus.e_valE, 64'h1F8);

        for (int i = 0; i < 8; i++) begin
            ld_op(4'(i), va[i], vb[i]); tick();
            ld((i == 3) ? 3'd2 : 3'd1, 4'd2, 4'(i), 64'd0, va[i], 64'd0,
               4'(i), 4'hF, 4'd1, 4'hF); tick();
            ld(3'd1, 4'd7, 4'(i), 64'h123, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF); tick();
        end

        ld_op(4'd1, 64'd1, 64'd0); tick();
        ld(3'd1, 4'd7, 4'd2, 64'h80, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF); tick();
        chk("jl_cc",  64'(bus.cc),    64'b010);
        chk("jl_cnd", 64'(bus.e_Cnd), 64'd1);
        rst = 1'b1;
        ld_op(4'd0, 64'd1, 64'd1); tick();
        chk("mid_rst_icode", 64'(bus.E_icode), 64'd1);
        chk("mid_rst_stat",  64'(bus.E_stat),  64'd1);
        chk("mid_rst_cc",    64'(bus.cc),      64'b100);
        chk("mid_rst_cnd",   64'(bus.e_Cnd),   64'd0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
